alu_operand_loader: RTL and testbench

- Upstream stage of the board-level ALU/7-segment datapath.
- Debounces three raw push-buttons, captures the switch bank into operand A, operand B and opcode registers in a fixed order, and presents them to the ALU.
- The ALU result then feeds the binary-to-BCD display stage.
- Provides a valid level, a load strobe and a state code for LEDs.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_operand_loader_debouncer.sv | 48 ++++
 rtl/alu_operand_loader.sv | 142 ++++++++++++++
 tb/tb_alu_operand_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state codes, legal opcodes and default widths.
// Used by the operand loader and the ALU itself.
package alu_pkg;

   localparam int BUS_DEF = 8;
   localparam int OP_DEF  = 6;

   typedef enum logic [1:0] {
      ST_WAIT_A  = 2'd0,
      ST_WAIT_B  = 2'd1,
      ST_WAIT_OP = 2'd2,
      ST_READY   = 2'd3
   } state_t;

   localparam logic [5:0] OPC_ADD = 6'b100000;
   localparam logic [5:0] OPC_SUB = 6'b100010;
   localparam logic [5:0] OPC_AND = 6'b100100;
   localparam logic [5:0] OPC_OR  = 6'b100101;
   localparam logic [5:0] OPC_XOR = 6'b100110;
   localparam logic [5:0] OPC_NOR = 6'b100111;
   localparam logic [5:0] OPC_SRL = 6'b000010;
   localparam logic [5:0] OPC_SRA = 6'b000011;

   function automatic logic opcode_legal(input logic [5:0] code);
      case (code)
         OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
         OPC_XOR, OPC_NOR, OPC_SRL, OPC_SRA: opcode_legal = 1'b1;
         default:                            opcode_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_operand_loader_debouncer.sv
// Button debouncer: 2-flop sync, stable-run counter, rising-edge press pulse.
// Latency: press pulse DEB_CYCLES+2 edges after the raw level settles; no backpressure.
// Glitches shorter than DEB_CYCLES cycles and releases never produce a pulse.
module btn_debouncer #(
   parameter int DEB_CYCLES = 500000,
   parameter int CNT_W      = 20
) (
   input  logic clock,
   input  logic reset_n,
   input  logic btn,
   output logic press
);

   logic             sync1_q;
   logic             sync2_q;
   logic             deb_q;
   logic             deb_d_q;
   logic             press_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         deb_d_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
         deb_d_q <= deb_q;
         press_q <= deb_q & ~deb_d_q;
         // Any sample agreeing with the debounced level restarts the stable run.
         if (sync2_q == deb_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            deb_q <= sync2_q;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign press = press_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Captures switches into op_a, op_b, op_code on debounced presses, in order A, B, OP.
// Latency: register + load_pulse DEB_CYCLES+3 edges after a stable press; no backpressure.
// OPCODE_CHECK_EN: reject illegal opcodes with an op_error pulse instead of loading.
module alu_operand_loader
   import alu_pkg::*;
#(
   parameter int BUS        = BUS_DEF,
   parameter int OP         = OP_DEF,
   parameter int DEB_CYCLES = 500000,
   parameter int CNT_W      = 20
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic [BUS-1:0] switches,
   input  logic           btn_a,
   input  logic           btn_b,
   input  logic           btn_op,
   output logic [BUS-1:0] op_a,
   output logic [BUS-1:0] op_b,
   output logic [OP-1:0]  op_code,
   output logic           operands_valid,
   output logic           load_pulse,
   output logic [1:0]     state,
   output logic           op_error
);

   logic [2:0]     raw;
   logic [2:0]     press;
   state_t         state_q;
   state_t         state_nxt;
   logic [BUS-1:0] op_a_q;
   logic [BUS-1:0] op_b_q;
   logic [OP-1:0]  op_code_q;
   logic           load_q;
   logic           ld_a;
   logic           ld_b;
   logic           ld_op;
   logic           rej;
   logic           op_ok;

   assign raw = {btn_op, btn_b, btn_a};

   for (genvar i = 0; i < 3; i++) begin : g_btn
      btn_debouncer #(
         .DEB_CYCLES(DEB_CYCLES),
         .CNT_W     (CNT_W)
      ) u_deb (
         .clock  (clock),
         .reset_n(reset_n),
         .btn    (raw[i]),
         .press  (press[i])
      );
   end

`ifdef OPCODE_CHECK_EN
   logic err_q;

   assign op_ok = opcode_legal(switches[5:0]);

   always_ff @(posedge clock) begin
      if (!reset_n) err_q <= 1'b0;
      else          err_q <= rej;
   end

   assign op_error = err_q;
`else
   logic unused_rej;

   assign op_ok      = 1'b1;
   assign unused_rej = rej;
   assign op_error   = 1'b0;
`endif

   // Only the press that is meaningful in the current state is taken; others drop.
   always_comb begin
      state_nxt = state_q;
      ld_a      = 1'b0;
      ld_b      = 1'b0;
      ld_op     = 1'b0;
      rej       = 1'b0;
      case (state_q)
         ST_WAIT_A: begin
            if (press[0]) begin
               ld_a      = 1'b1;
               state_nxt = ST_WAIT_B;
            end
         end
         ST_WAIT_B: begin
            if (press[1]) begin
               ld_b      = 1'b1;
               state_nxt = ST_WAIT_OP;
            end
         end
         ST_WAIT_OP: begin
            if (press[2]) begin
               if (op_ok) begin
                  ld_op     = 1'b1;
                  state_nxt = ST_READY;
               end else begin
                  rej = 1'b1;
               end
            end
         end
         ST_READY: begin
            if (press[0]) begin
               ld_a      = 1'b1;
               state_nxt = ST_WAIT_B;
            end else if (press[1]) begin
               ld_b = 1'b1;
            end else if (press[2]) begin
               if (op_ok) ld_op = 1'b1;
               else       rej   = 1'b1;
            end
         end
         default: state_nxt = ST_WAIT_A;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= ST_WAIT_A;
         op_a_q    <= '0;
         op_b_q    <= '0;
         op_code_q <= '0;
         load_q    <= 1'b0;
      end else begin
         state_q <= state_nxt;
         if (ld_a)  op_a_q    <= switches;
         if (ld_b)  op_b_q    <= switches;
         if (ld_op) op_code_q <= switches[OP-1:0];
         load_q <= ld_a | ld_b | ld_op;
      end
   end

   assign op_a           = op_a_q;
   assign op_b           = op_b_q;
   assign op_code        = op_code_q;
   assign load_pulse     = load_q;
   assign state          = state_q;
   assign operands_valid = (state_q == ST_READY);

endmodule

// File: tb/tb_alu_operand_loader.sv
// Randomised + directed bench for alu_operand_loader against a cycle-level reference model.
module tb_alu_operand_loader;

   localparam int DEB = 4;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] switches = 8'h00;
   logic       btn_a = 1'b0;
   logic       btn_b = 1'b0;
   logic       btn_op = 1'b0;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic [5:0] op_code;
   logic       operands_valid;
   logic       load_pulse;
   logic [1:0] state;
   logic       op_error;

   always #5 clock = ~clock;

   alu_operand_loader #(
      .BUS(8), .OP(6), .DEB_CYCLES(DEB), .CNT_W(20)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .switches      (switches),
      .btn_a         (btn_a),
      .btn_b         (btn_b),
      .btn_op        (btn_op),
      .op_a          (op_a),
      .op_b          (op_b),
      .op_code       (op_code),
      .operands_valid(operands_valid),
      .load_pulse    (load_pulse),
      .state         (state),
      .op_error      (op_error)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: raw-sample history per button, run-length debounce rule,
   // press seen by the FSM two edges after the debounced level rises.
   bit         hist[3][$];
   bit         deb[3];
   bit         rose[3];
   bit         prs[3];
   int         m_state;
   logic [7:0] m_a, m_b;
   logic [5:0] m_op;
   bit         m_load, m_err;

   logic [5:0] legal_list[8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                 6'b100110, 6'b100111, 6'b000010, 6'b000011};

   function automatic bit op_accept(input logic [5:0] c);
      bit ok;
`ifdef OPCODE_CHECK_EN
      ok = 1'b0;
      foreach (legal_list[i]) if (legal_list[i] == c) ok = 1'b1;
`else
      ok = 1'b1;
`endif
      return ok;
   endfunction

   task automatic model_edge(input bit rst_n, input bit [2:0] raw, input logic [7:0] sw);
      bit all_diff;
      bit s;
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            hist[i].delete();
            deb[i] = 0; rose[i] = 0; prs[i] = 0;
         end
         m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_load = 0; m_err = 0;
      end else begin
         m_load = 0;
         m_err  = 0;
         if (m_state == 0) begin
            if (prs[0]) begin m_a = sw; m_state = 1; m_load = 1; end
         end else if (m_state == 1) begin
            if (prs[1]) begin m_b = sw; m_state = 2; m_load = 1; end
         end else if (m_state == 2) begin
            if (prs[2]) begin
               if (op_accept(sw[5:0])) begin m_op = sw[5:0]; m_state = 3; m_load = 1; end
               else m_err = 1;
            end
         end else begin
            if (prs[0]) begin m_a = sw; m_state = 1; m_load = 1; end
            else if (prs[1]) begin m_b = sw; m_load = 1; end
            else if (prs[2]) begin
               if (op_accept(sw[5:0])) begin m_op = sw[5:0]; m_load = 1; end
               else m_err = 1;
            end
         end
         for (int i = 0; i < 3; i++) begin
            prs[i]  = rose[i];
            rose[i] = 0;
            hist[i].push_front(raw[i]);
            while (hist[i].size() > DEB + 2) void'(hist[i].pop_back());
            // Samples 2..DEB+1 back are the synchronised levels the counter has seen.
            all_diff = 1;
            for (int j = 2; j < DEB + 2; j++) begin
               s = (j < hist[i].size()) ? hist[i][j] : 1'b0;
               if (s == deb[i]) all_diff = 0;
            end
            if (all_diff) begin
               deb[i]  = ~deb[i];
               rose[i] = deb[i];
            end
         end
      end
   endtask

   int ncyc = 0;
   int pulses = 0;
   int errs = 0;
   int last_load = -1;

   task automatic cyc();
      bit [2:0]   raw;
      logic [7:0] sw;
      bit         r;
      raw = {btn_op, btn_b, btn_a};
      sw  = switches;
      r   = reset_n;
      @(posedge clock);
      ncyc++;
      model_edge(r, raw, sw);
      #1;
      check("op_a", 32'(op_a), 32'(m_a));
      check("op_b", 32'(op_b), 32'(m_b));
      check("op_code", 32'(op_code), 32'(m_op));
      check("state", 32'(state), 32'(m_state));
      check("operands_valid", 32'(operands_valid), 32'(m_state == 3));
      check("load_pulse", 32'(load_pulse), 32'(m_load));
      check("op_error", 32'(op_error), 32'(m_err));
      if (load_pulse) begin pulses++; last_load = ncyc; end
      if (op_error) errs++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic set_btn(input int idx, input bit v);
      case (idx)
         0:       btn_a  = v;
         1:       btn_b  = v;
         default: btn_op = v;
      endcase
   endtask

   task automatic push(input int idx, input int hi, input int lo);
      set_btn(idx, 1);
      run(hi);
      set_btn(idx, 0);
      run(lo);
   endtask

   task automatic do_reset();
      reset_n = 0;
      cyc();
      reset_n = 1;
      pulses = 0;
      errs = 0;
   endtask

   initial begin
      int k;
      int p0;
      do_reset();
      run(2);
      check("reset_state", 32'(state), 32'd0);

      // Single A capture and latency.
      switches = 8'h2A;
      k = ncyc + 1;
      push(0, 10, 10);
      check("a_value", 32'(op_a), 32'h2A);
      check("a_latency", 32'(last_load), 32'(k + 7));
      check("a_pulses", 32'(pulses), 32'd1);
      check("a_state", 32'(state), 32'd1);
      check("a_valid", 32'(operands_valid), 32'd0);

      // Full sequence to READY.
      do_reset();
      switches = 8'h05; push(0, 10, 8);
      switches = 8'h03; push(1, 10, 8);
      switches = 8'h20; push(2, 10, 8);
      check("seq_state", 32'(state), 32'd3);
      check("seq_valid", 32'(operands_valid), 32'd1);
      check("seq_opcode", 32'(op_code), 32'h20);
      check("seq_b", 32'(op_b), 32'h03);
      check("seq_pulses", 32'(pulses), 32'd3);

      // Short glitch ignored; a gap inside a long press gives one press.
      do_reset();
      switches = 8'h11; push(0, 10, 8);
      p0 = pulses;
      switches = 8'h22; push(1, 3, 10);
      check("glitch_state", 32'(state), 32'd1);
      check("glitch_pulses", 32'(pulses - p0), 32'd0);
      btn_b = 1; run(8); btn_b = 0; run(3); btn_b = 1; run(9); btn_b = 0; run(10);
      check("gap_pulses", 32'(pulses - p0), 32'd1);
      check("gap_state", 32'(state), 32'd2);

      // Simultaneous A and B in WAIT_A.
      do_reset();
      switches = 8'h5C;
      btn_a = 1; btn_b = 1; run(10); btn_a = 0; btn_b = 0; run(10);
      check("sim_a", 32'(op_a), 32'h5C);
      check("sim_state", 32'(state), 32'd1);
      check("sim_b", 32'(op_b), 32'd0);

      // Reload A from READY, then reset.
      switches = 8'h07; push(1, 10, 8);
      switches = 8'h26; push(2, 10, 8);
      switches = 8'hFF; push(0, 10, 8);
      check("ra_a", 32'(op_a), 32'hFF);
      check("ra_state", 32'(state), 32'd1);
      check("ra_valid", 32'(operands_valid), 32'd0);
      reset_n = 0; cyc(); reset_n = 1;
      check("rst_outputs", 32'({op_a, op_b, op_code, operands_valid, load_pulse, op_error}), 32'd0);
      check("rst_state", 32'(state), 32'd0);

`ifdef OPCODE_CHECK_EN
      switches = 8'h01; push(0, 10, 8);
      switches = 8'h02; push(1, 10, 8);
      switches = 8'h3F; push(2, 10, 8);
      check("rej_err", 32'(errs), 32'd1);
      check("rej_state", 32'(state), 32'd2);
      check("rej_opcode", 32'(op_code), 32'd0);
      switches = 8'h22; push(2, 10, 8);
      check("acc_state", 32'(state), 32'd3);
      check("acc_opcode", 32'(op_code), 32'h22);
`endif

      // Random phase: random button hold lengths, switch changes, rare resets.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) btn_a  = ~btn_a;
         if ($urandom_range(0, 5) == 0) btn_b  = ~btn_b;
         if ($urandom_range(0, 5) == 0) btn_op = ~btn_op;
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0) switches = 8'($urandom);
            else switches = {2'($urandom), legal_list[$urandom_range(0, 7)]};
         end
         reset_n = ($urandom_range(0, 399) != 0);
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
